// File: rtl/intersection_ctrl_pkg.sv
// Shared definitions for the intersection controller: phase codes, lamp
// encodings, counter/lamp widths and default phase timings.
package intersection_ctrl_pkg;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned LAMP_W  = 3;
  localparam int unsigned PHASE_W = 3;

  localparam logic [LAMP_W-1:0] LAMP_GRN = 3'b001;
  localparam logic [LAMP_W-1:0] LAMP_YEL = 3'b010;
  localparam logic [LAMP_W-1:0] LAMP_RED = 3'b100;

  localparam int unsigned T_GREEN_DEF  = 10;
  localparam int unsigned T_YELLOW_DEF = 3;
  localparam int unsigned T_ALLRED_DEF = 1;
  localparam int unsigned T_WALK_DEF   = 5;

  // Code 3'd7 is never entered; WALK is also unreachable without the pedestrian feature.
  typedef enum logic [PHASE_W-1:0] {
    A_GRN  = 3'd0,
    A_YEL  = 3'd1,
    RED_AB = 3'd2,
    B_GRN  = 3'd3,
    B_YEL  = 3'd4,
    RED_BA = 3'd5,
    WALK   = 3'd6
  } state_e;

endpackage

// File: rtl/phase_timer.sv
// Dwell counter for one phase: clears on phase entry, counts up and
// saturates at len_i-1, where done_c is asserted.
module phase_timer
  import intersection_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] len_i,
  output logic             done_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign done_c = (cnt_q == len_i - CNT_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (!done_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/intersection_ctrl.sv
// Two-street traffic light controller with car sensing on street B and an
// optional pedestrian walk phase, enabled by defining PED_REQ_EN.
module intersection_ctrl
  import intersection_ctrl_pkg::*;
#(
  parameter int unsigned T_GREEN  = T_GREEN_DEF,
  parameter int unsigned T_YELLOW = T_YELLOW_DEF,
  parameter int unsigned T_ALLRED = T_ALLRED_DEF,
  parameter int unsigned T_WALK   = T_WALK_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bt,
  input  logic               car_b,
  output logic [LAMP_W-1:0]  A,
  output logic [LAMP_W-1:0]  B,
  output logic               walk,
  output logic [PHASE_W-1:0] phase
);

  state_e            state_q;
  state_e            state_d;
  logic              car_pend_q;
  logic              car_pend_d;
  logic [LAMP_W-1:0] a_q;
  logic [LAMP_W-1:0] a_d;
  logic [LAMP_W-1:0] b_q;
  logic [LAMP_W-1:0] b_d;
  logic [CNT_W-1:0]  len_c;
  logic              done_c;
  logic              clr_c;
  logic              go_c;
  logic              illegal_c;

`ifdef PED_REQ_EN
  logic ped_pend_q;
  logic ped_pend_d;
  logic walk_q;
  logic walk_d;
`else
  logic unused_bt;
  assign unused_bt = bt;
`endif

  phase_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr_c),
    .len_i  (len_c),
    .done_c (done_c)
  );

  // Next phase, dwell length of the current phase and the lamps for the next cycle.
  always_comb begin
    state_d   = state_q;
    len_c     = CNT_W'(T_GREEN);
    illegal_c = 1'b0;
    a_d       = LAMP_RED;
    b_d       = LAMP_RED;
`ifdef PED_REQ_EN
    walk_d    = 1'b0;
    go_c      = car_pend_q | ped_pend_q;
`else
    go_c      = car_pend_q;
`endif

    case (state_q)
      A_GRN: begin
        len_c = CNT_W'(T_GREEN);
        if (done_c && go_c) state_d = A_YEL;
      end
      A_YEL: begin
        len_c = CNT_W'(T_YELLOW);
        if (done_c) state_d = RED_AB;
      end
      RED_AB: begin
        len_c = CNT_W'(T_ALLRED);
        if (done_c) state_d = B_GRN;
      end
      B_GRN: begin
        len_c = CNT_W'(T_GREEN);
        if (done_c) state_d = B_YEL;
      end
      B_YEL: begin
        len_c = CNT_W'(T_YELLOW);
        if (done_c) state_d = RED_BA;
      end
      RED_BA: begin
        len_c = CNT_W'(T_ALLRED);
        if (done_c) state_d = A_GRN;
`ifdef PED_REQ_EN
        if (done_c && ped_pend_q) state_d = WALK;
`endif
      end
`ifdef PED_REQ_EN
      WALK: begin
        len_c = CNT_W'(T_WALK);
        if (done_c) state_d = A_GRN;
      end
`endif
      default: begin
        state_d   = A_GRN;
        illegal_c = 1'b1;
      end
    endcase

    clr_c = (state_d != state_q);

    // Recovery from a bad code shows all red for one cycle before A goes green.
    if (!illegal_c) begin
      case (state_d)
        A_GRN:   a_d = LAMP_GRN;
        A_YEL:   a_d = LAMP_YEL;
        B_GRN:   b_d = LAMP_GRN;
        B_YEL:   b_d = LAMP_YEL;
`ifdef PED_REQ_EN
        WALK:    walk_d = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  // Pending requests; clearing on phase entry wins over a same-cycle request.
  always_comb begin
    car_pend_d = car_pend_q | car_b;
    if (clr_c && state_d == B_GRN) car_pend_d = 1'b0;
`ifdef PED_REQ_EN
    ped_pend_d = ped_pend_q | (bt && state_q != WALK);
    if (clr_c && state_d == WALK) ped_pend_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= A_GRN;
      car_pend_q <= 1'b0;
      a_q        <= LAMP_GRN;
      b_q        <= LAMP_RED;
    end else begin
      state_q    <= state_d;
      car_pend_q <= car_pend_d;
      a_q        <= a_d;
      b_q        <= b_d;
    end
  end

`ifdef PED_REQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ped_pend_q <= 1'b0;
      walk_q     <= 1'b0;
    end else begin
      ped_pend_q <= ped_pend_d;
      walk_q     <= walk_d;
    end
  end

  assign walk = walk_q;
`else
  assign walk = 1'b0;
`endif

  assign A     = a_q;
  assign B     = b_q;
  assign phase = state_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Self-checking bench for intersection_ctrl: directed scenarios plus random
// car/button traffic compared every cycle against a phase/countdown model.
module tb_intersection_ctrl;
  import intersection_ctrl_pkg::*;

  localparam int unsigned TG = 4;
  localparam int unsigned TY = 2;
  localparam int unsigned TA = 1;
  localparam int unsigned TW = 3;
`ifdef PED_REQ_EN
  localparam int unsigned EXP_WALK = TW;
`else
  localparam int unsigned EXP_WALK = 0;
`endif

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       bt    = 1'b0;
  logic       car_b = 1'b0;
  logic [2:0] a_o;
  logic [2:0] b_o;
  logic       walk_o;
  logic [2:0] phase_o;

  intersection_ctrl #(
    .T_GREEN  (TG),
    .T_YELLOW (TY),
    .T_ALLRED (TA),
    .T_WALK   (TW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bt    (bt),
    .car_b (car_b),
    .A     (a_o),
    .B     (b_o),
    .walk  (walk_o),
    .phase (phase_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: current phase, cycles left in it, latched requests.
  state_e m_ph   = A_GRN;
  int     m_left = TG;
  bit     m_car  = 1'b0;
  bit     m_ped  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int dur(input state_e p);
    case (p)
      A_GRN, B_GRN:  return TG;
      A_YEL, B_YEL:  return TY;
      WALK:          return TW;
      default:       return TA;
    endcase
  endfunction

  function automatic logic [2:0] exp_a(input state_e p);
    return (p == A_GRN) ? G : (p == A_YEL) ? Y : R;
  endfunction

  function automatic logic [2:0] exp_b(input state_e p);
    return (p == B_GRN) ? G : (p == B_YEL) ? Y : R;
  endfunction

  task automatic model_reset();
    m_ph   = A_GRN;
    m_left = TG;
    m_car  = 1'b0;
    m_ped  = 1'b0;
  endtask

  task automatic model_step(input logic c, input logic p);
    state_e nxt = m_ph;
    bit     ent;
    if (m_left > 1) begin
      m_left--;
    end else begin
      case (m_ph)
        A_GRN:  if (m_car || m_ped) nxt = A_YEL;
        A_YEL:  nxt = RED_AB;
        RED_AB: nxt = B_GRN;
        B_GRN:  nxt = B_YEL;
        B_YEL:  nxt = RED_BA;
        RED_BA: nxt = m_ped ? WALK : A_GRN;
        default: nxt = A_GRN;
      endcase
    end
    ent = (nxt != m_ph);
    if (ent && nxt == B_GRN) m_car = 1'b0;
    else if (c)              m_car = 1'b1;
`ifdef PED_REQ_EN
    if (ent && nxt == WALK)       m_ped = 1'b0;
    else if (p && m_ph != WALK)   m_ped = 1'b1;
`else
    if (p) m_ped = 1'b0;
`endif
    if (ent) m_left = dur(nxt);
    m_ph = nxt;
  endtask

  task automatic check_outputs();
    check("A", 32'(a_o), 32'(exp_a(m_ph)));
    check("B", 32'(b_o), 32'(exp_b(m_ph)));
    check("walk", 32'(walk_o), 32'(m_ph == WALK));
    check("phase", 32'(phase_o), 32'(m_ph));
    check("excl", 32'(a_o != R && b_o != R), 32'd0);
  endtask

  task automatic tick(input logic c, input logic p);
    car_b = c;
    bt    = p;
    @(posedge clk);
    model_step(c, p);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic reset_dut();
    car_b = 1'b0;
    bt    = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    check_outputs();
    rst = 1'b0;
  endtask

  task automatic run_until(input state_e tgt, input logic c, input logic p, input int budget);
    int n = 0;
    while (m_ph != tgt && n < budget) begin
      tick(c, p);
      n++;
    end
    check("reach_phase", 32'(phase_o), 32'(tgt));
  endtask

  initial begin
    int n;
    int nwalk;
    bit left_a;

    // Held in reset, then idle for 50 cycles.
    reset_dut();
    for (int i = 0; i < 50; i++) tick(1'b0, 1'b0);

    // Single car pulse on the first counted cycle: full B service, back to A green.
    reset_dut();
    n = 0;
    left_a = 1'b0;
    while (n < 40) begin
      tick(n == 0, 1'b0);
      n++;
      if (a_o != G) left_a = 1'b1;
      else if (left_a) break;
    end
    check("car_cycle_len", 32'(n), 32'(2 * (TG + TY + TA)));

    // Button pulse during B green gives one walk phase afterwards.
    reset_dut();
    tick(1'b1, 1'b0);
    run_until(B_GRN, 1'b0, 1'b0, 20);
    tick(1'b0, 1'b1);
    nwalk = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0);
      if (walk_o) nwalk++;
    end
    check("walk_len", 32'(nwalk), 32'(EXP_WALK));

    // Button held from B green through the walk phase: no second walk.
    run_until(B_GRN, 1'b1, 1'b0, 40);
    nwalk = 0;
    n = 0;
    while (m_ph != A_GRN && n < 40) begin
      tick(1'b0, 1'b1);
      if (walk_o) nwalk++;
      n++;
    end
    check("walk_held_len", 32'(nwalk), 32'(EXP_WALK));
    nwalk = 0;
    for (int i = 0; i < 30; i++) begin
      tick(i == 0, 1'b0);
      if (walk_o) nwalk++;
    end
    check("no_second_walk", 32'(nwalk), 32'd0);

    // Button pulses only, no cars.
    reset_dut();
    nwalk = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, (i % 7) == 2);
      if (walk_o) nwalk++;
    end
`ifndef PED_REQ_EN
    check("bt_ignored_walk", 32'(nwalk), 32'd0);
`endif

    // Asynchronous reset in the middle of B yellow.
    run_until(B_YEL, 1'b1, 1'b0, 40);
    car_b = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_A", 32'(a_o), 32'(G));
    check("arst_B", 32'(b_o), 32'(R));
    check("arst_walk", 32'(walk_o), 32'd0);
    check("arst_phase", 32'(phase_o), 32'(A_GRN));
    @(negedge clk);
    model_reset();
    check_outputs();
    rst = 1'b0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom % 8) == 0, ($urandom % 12) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/intersection_ctrl.md
INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

Interface
REQ-001 Parameter T_GREEN, default 10, minimum green time in cycles for each street (1..255).
REQ-002 Parameter T_YELLOW, default 3, yellow time in cycles (1..255).
REQ-003 Parameter T_ALLRED, default 1, all-red clearance time in cycles (1..255).
REQ-004 Parameter T_WALK, default 5, pedestrian walk time in cycles (1..255).
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 bt  input  1  pedestrian request button, level-sampled each cycle.
REQ-008 car_b  input  1  vehicle waiting on street B, level-sampled each cycle.
REQ-009 A  output  3  street A lamp, one-hot: 001 green, 010 yellow, 100 red.
REQ-010 B  output  3  street B lamp, same encoding as A.
REQ-011 walk  output  1  pedestrian walk lamp.
REQ-012 phase  output  3  current state code, for debug.

Function
REQ-013 States SHALL be: A_GRN, A_YEL, RED_AB, B_GRN, B_YEL, RED_BA and WALK.
REQ-014 Lamp map SHALL be:
- A_GRN: A=001, B=100.
- A_YEL: A=010, B=100.
- B_GRN: A=100, B=001.
- B_YEL: A=100, B=010.
- RED_AB, RED_BA and WALK: A=100, B=100.
- walk=1 only in WALK.
REQ-015 Outputs SHALL be registered and change on the same edge as the state register; no combinational path from any input to any output.
REQ-016 An 8-bit dwell counter SHALL clear to 0 on every state entry and increment each cycle; "done" means count == T-1, so a state lasts exactly T cycles.
REQ-017 Transitions:
- A_GRN to A_YEL when done and (car_pend or ped_pend); otherwise A_GRN holds indefinitely and the counter saturates at T_GREEN-1.
- A_YEL to RED_AB on done.
- RED_AB to B_GRN on done.
- B_GRN to B_YEL on done.
- B_YEL to RED_BA on done.
- RED_BA to WALK on done if ped_pend, otherwise to A_GRN on done.
- WALK to A_GRN on done.
REQ-018 car_pend SHALL set on any cycle with car_b=1 and clear on entry to B_GRN; a car_b=1 on the entry cycle leaves it clear.
REQ-019 ped_pend SHALL set on any cycle with bt=1 outside WALK and clear on entry to WALK; bt=1 on the entry cycle or during WALK is ignored.
REQ-020 The A/B lamp pair SHALL never show green or yellow on both streets in the same cycle.
REQ-021 An unreachable state code SHALL return to A_GRN on the next edge with all lamps red for that cycle.

Reset
REQ-022 While rst=1, the block SHALL hold: state A_GRN, A=001, B=100, walk=0, phase=A_GRN code, counter 0, car_pend 0, ped_pend 0.
REQ-023 Reset asserted mid-phase SHALL abort the phase immediately, with no yellow or all-red sequencing.
REQ-024 After reset release, the first counted cycle SHALL be the first rising edge with rst=0.

Configuration
REQ-025 Macro PED_REQ_EN SHALL control the pedestrian feature.
- Defined: WALK state, ped_pend and the walk output behave as above.
- Undefined: the bt port remains but is ignored; ped_pend and WALK are not built; walk is tied to 0; RED_BA always goes to A_GRN; A_GRN exit depends on car_pend only.

Structure
REQ-026 A shared package SHALL hold the state enum, the lamp encodings (LAMP_GRN, LAMP_YEL, LAMP_RED) and the default timing constants.
REQ-027 Sub-module phase_timer SHALL implement the 8-bit dwell counter, with clear, load-length and done ports; the FSM and pending flags stay in intersection_ctrl.

Verification
REQ-028 Bench parameters SHALL be T_GREEN=4, T_YELLOW=2, T_ALLRED=1 and T_WALK=3 for the scenarios below.
REQ-029 No requests -> A=001 and B=100 held for 50 cycles; phase constant.
REQ-030 car_b pulse at cycle 1 -> A green 4 cycles, A yellow 2, all-red 1, B green 4, B yellow 2, all-red 1, then A=001; total 14 cycles from reset release.
REQ-031 bt pulse during B_GRN -> after RED_BA, walk=1 with A=B=100 for exactly 3 cycles, then A_GRN.
REQ-032 bt held high through WALK -> no second WALK unless bt is asserted again after WALK.
REQ-033 rst asserted asynchronously mid B_YEL -> A=001, B=100 and walk=0 before the next clock edge.
REQ-034 With PED_REQ_EN undefined, bt pulses and no car_b -> A_GRN held and walk stays 0.
